mamba_step_scheduler: RTL and testbench
=======================================

# mamba_step_scheduler

Sequencing controller for the MAC → bias → sigmoid → λ-FIFO → join → EW state-update chain. On a single configuration handshake it runs `num_steps` timesteps. For each step it issues `D/TILE_SIZE` tile requests to the MAC input and marks the first tile of each step. It bounds in-flight tiles with a credit counter, owns the EW state address, and returns to idle once every issued tile has left the EW stage.

## Interface
Parameters:
- `TILE_SIZE`, 4: lanes per tile.
- `D`, 256: channels per timestep; `TILES_PER_STEP = D/TILE_SIZE` (64 at defaults).
- `S_ADDR_W`, 6: EW state address width; `TILES_PER_STEP <= 2**S_ADDR_W` is required.
- `MAX_OUTSTANDING`, 8: maximum tiles issued but not yet retired. Must be ≥1 and ≤ the λ-FIFO depth.
- `STEP_W`, 16: width of the step count.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `cfg_valid`, in, 1: start request.
- `cfg_ready`, out, 1: high only in IDLE.
- `cfg_num_steps`, in, `STEP_W`: timesteps to run; sampled on cfg fire.
- `mac_req_valid`, out, 1: drives MAC `s_axis_TVALID`.
- `mac_req_ready`, in, 1: MAC `s_axis_TREADY`.
- `mac_sof`, out, 1: high with `mac_req_valid` on tile 0 of each step.
- `ew_in_valid`, in, 1: join output valid.
- `ew_in_ready`, in, 1: combined join output ready. `ew_in_valid && ew_in_ready` is a join fire.
- `s_addr`, out, `S_ADDR_W`: EW state address for the current join beat.
- `ew_out_valid`, in, 1: EW `s_out_valid`.
- `ew_out_ready`, in, 1: EW `s_out_ready`. Their AND is a retire.
- `busy`, out, 1: high in ISSUE and DRAIN.
- `done`, out, 1: one-cycle pulse in DONE.
- `step_idx`, out, `STEP_W`: index of the step currently being issued.
- `outstanding`, out, `$clog2(MAX_OUTSTANDING+1)`: tiles currently in flight.
- `err_underflow`, out, 1: sticky flag; cleared on cfg fire.

## Operation
- FSM with four states: IDLE, ISSUE, DRAIN, DONE. All outputs are derived from registers and the current state; none depend combinationally on a ready input.
- **IDLE → ISSUE** on cfg fire with `cfg_num_steps > 0`. The cfg fire latches the count and clears `tile_cnt`, `step_idx`, `s_addr` and `err_underflow`.
- **IDLE → DONE** on cfg fire with `cfg_num_steps == 0`. No requests are issued.
- **ISSUE:** `mac_req_valid = (outstanding < MAX_OUTSTANDING)`.
  - On issue fire, `tile_cnt` increments. At `TILES_PER_STEP-1` it wraps to 0 and `step_idx` increments.
  - The fire of the final tile of the final step moves the FSM to DRAIN.
- **DRAIN:** `mac_req_valid = 0`. Moves to DONE in the cycle after `outstanding == 0` is observed.
- **DONE:** `done = 1` for exactly one cycle, then IDLE.
- **Credit counter:** `outstanding` takes +1 on issue fire and −1 on retire. Simultaneous issue and retire leave it unchanged.
- **Underflow:** a retire while `outstanding == 0` sets `err_underflow` and holds the counter at 0.
- **`s_addr`:** increments on each join fire and wraps from `TILES_PER_STEP-1` to 0. Join fires are counted in all states.
- `mac_sof = mac_req_valid && (tile_cnt == 0)`.
- **Reset mid-run:** every register returns to its reset value immediately. Tiles already in the datapath are not tracked; the datapath must be reset together with this block.

## Timing
- **Reset values:** state = IDLE, `cfg_ready = 1`, `mac_req_valid = 0`, `mac_sof = 0`, `s_addr = 0`, `busy = 0`, `done = 0`, `step_idx = 0`, `outstanding = 0`, `err_underflow = 0`.
- **Issue latency:** `mac_req_valid` rises in the first cycle after cfg fire, provided credit is available.
- **AXIS hold rule:** once `mac_req_valid` is high it stays high until `mac_req_ready`. Retires can only add credit, so this holds without extra logic.
- **Throughput:** one tile per cycle while credit is available.
- **DRAIN → DONE:** takes one cycle after the last retire. `cfg_ready` returns in the cycle after `done`.

## Structure
- Shared package `mamba_sched_pkg`:
  - FSM state typedef `sched_state_e` with values IDLE, ISSUE, DRAIN, DONE.
  - Function computing `TILES_PER_STEP`.
  - Credit counter width helper.
- One sub-module: `credit_counter`, holding the saturating up/down counter and the underflow flag.

## Test plan
1. **Single step, free flow.** `cfg_num_steps = 1`, all readies tied high. Expect 64 issues, `mac_sof` only on the first, `s_addr` 0..63 then wrap to 0, one `done` pulse, `outstanding = 0` at the end.
2. **Credit cap.** `MAX_OUTSTANDING = 8`, `ew_out_ready = 0`. Expect exactly 8 issues, then `mac_req_valid` held at 0 and `outstanding = 8`. Raise `ew_out_ready` for one retire; expect exactly one further issue.
3. **Simultaneous issue and retire.** Hold `outstanding = 5` with an issue and a retire in the same cycle. Expect `outstanding` to stay 5, `step_idx = 0`, `tile_cnt` +1.
4. **Multi-step with MAC backpressure.** `cfg_num_steps = 3`, `mac_req_ready` toggling randomly. Expect 192 issues, `mac_sof` on tiles 0, 64 and 128, `step_idx` ending at 2, `done` only after 192 retires.
5. **Zero steps and underflow.** `cfg_num_steps = 0` → `done` pulses the cycle after cfg fire with no issues. A spurious retire in IDLE sets `err_underflow`; the next cfg fire clears it.
6. **Reset mid-ISSUE.** Assert `rst` at tile 37 of step 1. Expect all outputs at their reset values in the same cycle, and a clean restart on the next cfg fire.

Source files
------------

// File: rtl/mamba_sched_pkg.sv
// Shared types and sizing helpers for the Mamba step scheduler.
package mamba_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  function automatic int unsigned tiles_per_step(input int unsigned d, input int unsigned tile_size);
    return d / tile_size;
  endfunction

  function automatic int unsigned credit_w(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/mamba_step_scheduler_credit.sv
// Saturating in-flight tile counter with a sticky underflow flag.
module credit_counter
  import mamba_sched_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_W           = credit_w(MAX_OUTSTANDING)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c,
  output logic             underflow
);

  logic uf_set;

  // Issue and retire in the same cycle cancel; a retire with nothing in flight is an error.
  always_comb begin
    count_nxt_c = count;
    uf_set      = 1'b0;
    if (inc && !dec) begin
      if (count != CNT_W'(MAX_OUTSTANDING)) count_nxt_c = count + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count == '0) uf_set = 1'b1;
      else             count_nxt_c = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt_c;
      underflow <= (underflow && !clr) || uf_set;
    end
  end

endmodule

// File: rtl/mamba_step_scheduler.sv
// Sequences MAC tile requests per timestep, bounds in-flight tiles and owns the EW state address.
module mamba_step_scheduler
  import mamba_sched_pkg::*;
#(
  parameter int unsigned TILE_SIZE       = 4,
  parameter int unsigned D               = 256,
  parameter int unsigned S_ADDR_W        = 6,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned STEP_W          = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [STEP_W-1:0]                      cfg_num_steps,
  output logic                                   mac_req_valid,
  input  logic                                   mac_req_ready,
  output logic                                   mac_sof,
  input  logic                                   ew_in_valid,
  input  logic                                   ew_in_ready,
  output logic [S_ADDR_W-1:0]                    s_addr,
  input  logic                                   ew_out_valid,
  input  logic                                   ew_out_ready,
  output logic                                   busy,
  output logic                                   done,
  output logic [STEP_W-1:0]                      step_idx,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_underflow
);

  localparam int unsigned TILES_PER_STEP = tiles_per_step(D, TILE_SIZE);
  localparam int unsigned CNT_W          = credit_w(MAX_OUTSTANDING);
  localparam int unsigned TILE_W         = S_ADDR_W;

  sched_state_e        state_q, state_nxt;
  logic [STEP_W-1:0]   num_steps_q;
  logic [TILE_W-1:0]   tile_cnt_q, tile_nxt;
  logic [STEP_W-1:0]   step_nxt;
  logic [S_ADDR_W-1:0] addr_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                valid_nxt, sof_nxt;

  logic cfg_fire, issue_fire, join_fire, retire;
  logic last_tile, last_step;

  assign cfg_fire   = cfg_valid && cfg_ready;
  assign issue_fire = mac_req_valid && mac_req_ready;
  assign join_fire  = ew_in_valid && ew_in_ready;
  assign retire     = ew_out_valid && ew_out_ready;
  assign last_tile  = (tile_cnt_q == TILE_W'(TILES_PER_STEP - 1));
  assign last_step  = (step_idx == num_steps_q - STEP_W'(1));

  credit_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .clr         (cfg_fire),
    .inc         (issue_fire),
    .dec         (retire),
    .count       (outstanding),
    .count_nxt_c (cnt_nxt),
    .underflow   (err_underflow)
  );

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_nxt = state_q;
    tile_nxt  = tile_cnt_q;
    step_nxt  = step_idx;
    addr_nxt  = s_addr;

    if (join_fire) begin
      addr_nxt = (s_addr == S_ADDR_W'(TILES_PER_STEP - 1)) ? '0 : s_addr + S_ADDR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          tile_nxt  = '0;
          step_nxt  = '0;
          addr_nxt  = '0;
          state_nxt = (cfg_num_steps == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_fire) begin
          if (last_tile) begin
            tile_nxt = '0;
            if (last_step) state_nxt = DRAIN;
            else           step_nxt  = step_idx + STEP_W'(1);
          end else begin
            tile_nxt = tile_cnt_q + TILE_W'(1);
          end
        end
      end
      DRAIN: begin
        if (outstanding == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    valid_nxt = (state_nxt == ISSUE) && (cnt_nxt < CNT_W'(MAX_OUTSTANDING));
    sof_nxt   = valid_nxt && (tile_nxt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cfg_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      mac_req_valid <= 1'b0;
      mac_sof       <= 1'b0;
      tile_cnt_q    <= '0;
      step_idx      <= '0;
      s_addr        <= '0;
      num_steps_q   <= '0;
    end else begin
      state_q       <= state_nxt;
      cfg_ready     <= (state_nxt == IDLE);
      busy          <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
      done          <= (state_nxt == DONE);
      mac_req_valid <= valid_nxt;
      mac_sof       <= sof_nxt;
      tile_cnt_q    <= tile_nxt;
      step_idx      <= step_nxt;
      s_addr        <= addr_nxt;
      if (cfg_fire) num_steps_q <= cfg_num_steps;
    end
  end

endmodule

// File: tb/tb_mamba_step_scheduler.sv
// Randomized self-checking bench for mamba_step_scheduler against a count-based reference model.
module tb_mamba_step_scheduler;

  localparam int unsigned TPS      = 64;
  localparam int unsigned MAX_OUT  = 8;
  localparam int unsigned STEP_W   = 16;
  localparam int unsigned S_ADDR_W = 6;
  localparam int unsigned CNT_W    = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_valid, cfg_ready;
  logic [STEP_W-1:0]   cfg_num_steps;
  logic                mac_req_valid, mac_req_ready, mac_sof;
  logic                ew_in_valid, ew_in_ready;
  logic [S_ADDR_W-1:0] s_addr;
  logic                ew_out_valid, ew_out_ready;
  logic                busy, done, err_underflow;
  logic [STEP_W-1:0]   step_idx;
  logic [CNT_W-1:0]    outstanding;

  mamba_step_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_num_steps (cfg_num_steps),
    .mac_req_valid (mac_req_valid),
    .mac_req_ready (mac_req_ready),
    .mac_sof       (mac_sof),
    .ew_in_valid   (ew_in_valid),
    .ew_in_ready   (ew_in_ready),
    .s_addr        (s_addr),
    .ew_out_valid  (ew_out_valid),
    .ew_out_ready  (ew_out_ready),
    .busy          (busy),
    .done          (done),
    .step_idx      (step_idx),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: run progress expressed as plain counts.
  bit m_run, m_done, m_err;
  int m_issued, m_total, m_steps, m_out, m_joins;

  int  p_mac, p_ret, p_join;
  bit  spurious_ok;
  bit  done_seen;
  int  obs_issue, obs_sof, obs_retire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    return m_run && (m_issued < m_total) && (m_out < int'(MAX_OUT));
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_err = 0;
    m_issued = 0; m_total = 0; m_steps = 0; m_out = 0; m_joins = 0;
  endtask

  task automatic check_all();
    int exp_step;
    bit mv;
    mv = m_valid();
    if (m_total == 0) exp_step = 0;
    else exp_step = (m_issued / TPS < m_steps - 1) ? m_issued / TPS : m_steps - 1;
    check("cfg_ready",     32'(cfg_ready),     32'(!m_run && !m_done));
    check("busy",          32'(busy),          32'(m_run));
    check("done",          32'(done),          32'(m_done));
    check("mac_req_valid", 32'(mac_req_valid), 32'(mv));
    check("mac_sof",       32'(mac_sof),       32'(mv && (m_issued % TPS == 0)));
    check("s_addr",        32'(s_addr),        32'(m_joins % TPS));
    check("step_idx",      32'(step_idx),      32'(exp_step));
    check("outstanding",   32'(outstanding),   32'(m_out));
    check("err_underflow", 32'(err_underflow), 32'(m_err));
    if (done) done_seen = 1;
  endtask

  // One clock: check at the negedge, drive inputs, advance the model, step to the next negedge.
  task automatic cycle(input bit cfg_v, input int n);
    bit mv, cf, iss, jn, ret, nd;
    check_all();
    cfg_valid     = cfg_v ? 1'b1 : (m_run ? 1'($urandom_range(1)) : 1'b0);
    cfg_num_steps = cfg_v ? STEP_W'(n) : STEP_W'($urandom_range(7));
    mac_req_ready = ($urandom_range(99) < p_mac);
    ew_in_valid   = ($urandom_range(99) < p_join);
    ew_in_ready   = ($urandom_range(99) < p_join);
    ret           = ($urandom_range(99) < p_ret) && ((m_out > 0) || spurious_ok);
    ew_out_valid  = ret ? 1'b1 : 1'($urandom_range(1));
    ew_out_ready  = ret ? 1'b1 : (ew_out_valid ? 1'b0 : 1'($urandom_range(1)));

    obs_issue  += int'(mac_req_valid && mac_req_ready);
    obs_sof    += int'(mac_sof && mac_req_ready);
    obs_retire += int'(ret);

    mv  = m_valid();
    cf  = cfg_valid && !m_run && !m_done;
    iss = mv && mac_req_ready;
    jn  = ew_in_valid && ew_in_ready;
    nd  = (m_run && m_issued == m_total && m_out == 0) || (cf && n == 0);
    m_err = (m_err && !cf) || (ret && !iss && m_out == 0);
    if (iss && !ret) m_out++;
    else if (ret && !iss && m_out > 0) m_out--;
    if (iss) m_issued++;
    if (cf) begin
      m_steps = n; m_total = n * TPS; m_issued = 0; m_joins = 0; m_run = (n > 0);
    end else if (jn) begin
      m_joins++;
    end
    if (nd) m_run = 0;
    m_done = nd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_done(input int budget);
    done_seen = 0;
    for (int k = 0; k < budget && !done_seen; k++) cycle(0, 0);
    check("done_reached", 32'(done_seen), 32'd1);
  endtask

  task automatic clear_obs();
    obs_issue = 0; obs_sof = 0; obs_retire = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    rst = 1; cfg_valid = 0; cfg_num_steps = '0; mac_req_ready = 0;
    ew_in_valid = 0; ew_in_ready = 0; ew_out_valid = 0; ew_out_ready = 0;
    spurious_ok = 0; p_mac = 100; p_ret = 100; p_join = 100;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 0;

    // Single step, free flow
    clear_obs();
    cycle(1, 1);
    run_until_done(300);
    check("t1_issues", 32'(obs_issue), 32'd64);
    check("t1_sofs",   32'(obs_sof),   32'd1);
    check("t1_outstanding", 32'(outstanding), 32'd0);

    // Credit cap
    clear_obs(); p_mac = 100; p_ret = 0; p_join = 50;
    cycle(1, 1);
    repeat (20) cycle(0, 0);
    check("t2_issues_capped", 32'(obs_issue), 32'd8);
    check("t2_outstanding",   32'(outstanding), 32'd8);
    check("t2_valid_held",    32'(mac_req_valid), 32'd0);
    p_ret = 100; cycle(0, 0);
    p_ret = 0; repeat (5) cycle(0, 0);
    check("t2_one_more", 32'(obs_issue), 32'd9);

    // Simultaneous issue and retire at outstanding 5
    p_mac = 0; p_ret = 100;
    repeat (3) cycle(0, 0);
    check("t3_out5", 32'(outstanding), 32'd5);
    p_mac = 100; p_ret = 100; cycle(0, 0);
    p_mac = 0; p_ret = 0;
    check("t3_out_hold", 32'(outstanding), 32'd5);
    check("t3_step",     32'(step_idx), 32'd0);
    check("t3_issued",   32'(obs_issue), 32'd10);
    p_mac = 100; p_ret = 100;
    run_until_done(400);

    // Multi-step with MAC backpressure
    clear_obs(); p_mac = 50; p_ret = 60; p_join = 70;
    cycle(1, 3);
    run_until_done(4000);
    check("t4_issues",  32'(obs_issue),  32'd192);
    check("t4_sofs",    32'(obs_sof),    32'd3);
    check("t4_retires", 32'(obs_retire), 32'd192);
    check("t4_step",    32'(step_idx),   32'd2);

    // Zero steps, then underflow and its clear
    clear_obs(); p_mac = 100; p_ret = 0;
    cycle(1, 0);
    check("t5_done_pulse", 32'(done), 32'd1);
    cycle(0, 0);
    spurious_ok = 1; p_ret = 100; cycle(0, 0);
    spurious_ok = 0; p_ret = 0; cycle(0, 0);
    check("t5_no_issue", 32'(obs_issue), 32'd0);
    check("t5_err_set",  32'(err_underflow), 32'd1);
    p_ret = 100;
    cycle(1, 1);
    check("t5_err_clr", 32'(err_underflow), 32'd0);
    run_until_done(400);

    // Reset in the middle of step 1
    p_mac = 80; p_ret = 70; p_join = 60;
    cycle(1, 2);
    reached = 0;
    for (int k = 0; k < 2000 && !reached; k++) begin
      if (m_issued == TPS + 37) reached = 1;
      else cycle(0, 0);
    end
    check("t6_reach_tile37", 32'(reached), 32'd1);
    rst = 1;
    #1;
    model_reset();
    check_all();
    check("t6_rst_valid", 32'(mac_req_valid), 32'd0);
    @(negedge clk);
    check_all();
    rst = 0;
    clear_obs(); p_mac = 100; p_ret = 100;
    cycle(1, 1);
    run_until_done(400);
    check("t6_restart_issues", 32'(obs_issue), 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
